mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-outstanding memory bus between the core's instruction-fetch port and its load/store port. It sits between the pipeline and the unified memory/interconnect port. It generates the `i_ready`/`d_ready` completion pulses that the pipeline's hazard logic uses to stall on imem/dmem not-ready. Data side has priority, with a bounded starvation guarantee for fetch.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `STARVE_MAX`, 4: maximum consecutive D grants while a fetch waits; must be ≥1.
- `TIMEOUT_CYC`, 256: bus wait limit in cycles (used only with `MEM_ARB_TIMEOUT_EN`).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  fetch request; held with `i_addr` until `i_ready`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_ready`  out  1  one-cycle completion pulse; `i_rdata` is valid in the same cycle.
- `i_rdata`  out  DATA_W  fetched word.
- `d_valid`  in  1  load/store request; held stable until `d_ready`.
- `d_we`  in  1  1 = store.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_wstrb`  in  DATA_W/8  byte strobes.
- `d_ready`  out  1  one-cycle completion pulse.
- `d_rdata`  out  DATA_W  load data; 0 after a store.
- `m_valid`  out  1  bus request; held until `m_ready`.
- `m_we`, `m_addr`, `m_wdata`, `m_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  registered bus request fields.
- `m_ready`  in  1  bus accept/complete; `m_rdata` is valid in the same cycle.
- `m_rdata`  in  DATA_W  bus read data.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky bus-timeout flag.

## Operation
- FSM states: IDLE, I_BUS, D_BUS, RESP.
- IDLE, grant rule:
  - D wins if `d_valid` && (`!i_valid` || starve_cnt < STARVE_MAX).
  - Otherwise I wins if `i_valid`.
  - With no request, stay in IDLE.
- On grant:
  - Register the winner's fields onto `m_*`.
  - Set `m_valid`=1 on the next cycle; enter I_BUS or D_BUS.
  - Fetch grants drive `m_we`=0 and `m_wstrb`=0.
- starve_cnt:
  - +1 on each D grant made while `i_valid`=1, saturating at STARVE_MAX.
  - Cleared on each I grant.
- I_BUS/D_BUS: hold every `m_*` field. On `m_ready`:
  - Drop `m_valid`.
  - Capture `m_rdata` into `i_rdata`/`d_rdata`; `d_rdata` becomes 0 for a store.
  - Enter RESP.
- RESP:
  - Pulse the owner's `*_ready` for exactly one cycle.
  - No grant is made in this cycle; a requester's `valid` seen in RESP is treated as already consumed.
  - Return to IDLE.
- A granted transaction always completes. If `i_valid` drops mid-transaction (branch redirect), the bus access still finishes and `i_ready` still pulses; the fetch unit discards the data.
- Both `valid`s high with starve_cnt == STARVE_MAX: I is granted, then D on the next IDLE.
- `i_rdata`/`d_rdata` hold their value until the next completion for that side.

## Timing
- Reset (async assert) values:
  - `m_valid`, `i_ready`, `d_ready`, `busy`, `err` = 0.
  - All data/address outputs = 0.
  - FSM = IDLE; starve_cnt = 0.
- Reset asserted mid-transaction drops `m_valid` immediately; the abandoned bus access is not completed.
- Zero-wait bus, request sampled in IDLE at cycle 0:
  - `m_valid` high at cycle 1 (with `m_ready`).
  - `*_ready` pulse at cycle 2.
  - Next grant possible at cycle 3.
  - Peak throughput: 1 access per 3 cycles.
- Each bus wait cycle adds 1 to latency.
- `*_ready` never asserts in the same cycle as `m_valid`.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs in I_BUS/D_BUS while `m_ready`=0.
  - On reaching TIMEOUT_CYC-1: drop `m_valid`, enter RESP with rdata=0, set `err` (cleared only by reset).
- `MEM_ARB_TIMEOUT_EN` not defined: wait indefinitely; `err` tied to 0; no counter logic.

## Structure
- Package `mem_arb_pkg` holds:
  - FSM state encoding (2-bit: IDLE=0, I_BUS=1, D_BUS=2, RESP=3).
  - Owner encoding (OWN_I/OWN_D).
  - Default STARVE_MAX/TIMEOUT_CYC constants.
- One sub-module, `mem_arb_timeout`: wait counter with clear/enable/expire, instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Single fetch:** `i_valid`=1, addr 0x100, `m_ready`=1 with `m_rdata`=0x00000013 → `m_addr`=0x100 at cycle 1; `i_ready` pulse with `i_rdata`=0x13 at cycle 2.
- **Store then load:** store 0x200 ← 0xDEADBEEF, strb 0xF → `m_we`=1, `d_ready` pulse, `d_rdata`=0. Then load 0x200, bus returns 0xDEADBEEF → `d_rdata`=0xDEADBEEF.
- **Starvation:** `i_valid` and `d_valid` held high continuously with STARVE_MAX=4 → 4 D grants, then 1 I grant, repeating; starve_cnt clears on the I grant.
- **Wait states / redirect:** `m_ready` low for 5 cycles and `i_valid` dropped at cycle 2 → `m_valid`/`m_addr` stable throughout; `i_ready` still pulses 1 cycle after `m_ready`.
- **Reset mid-op:** `rst_n` low while in D_BUS → `m_valid`=0 asynchronously; after release, `busy`=0 and the first grant follows normal priority.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8):** `m_ready` held 0 → `m_valid` drops after 8 cycles; `d_ready` pulses with `d_rdata`=0; `err`=1 and stays set.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared encodings and default constants for mem_port_arbiter
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_BUS = 2'd1,
        D_BUS = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int C_STARVE_MAX_DEF  = 4;
    localparam int C_TIMEOUT_CYC_DEF = 256;

endpackage

`default_nettype wire

// File: rtl/mem_arb_timeout.sv
// ----------------------------------------------------------------------------
// mem_arb_timeout : bus wait counter; expire flags the last allowed wait cycle
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb_timeout #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int C_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYC - 1);

    logic [C_CNT_W-1:0] r_cnt;

    assign expire = en && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter : fetch/load-store arbiter onto one single-outstanding bus,
//                    data priority with bounded fetch starvation.
//                    Optional bus timeout enabled by MEM_ARB_TIMEOUT_EN.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = C_STARVE_MAX_DEF,
    parameter int TIMEOUT_CYC = C_TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy,
    output logic                err
);

    localparam int C_STRB_W = DATA_W / 8;
    localparam int C_CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [C_CNT_W-1:0] C_STARVE_MAX = C_CNT_W'(STARVE_MAX);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    arb_owner_t            r_owner;
    logic [C_CNT_W-1:0]    r_starve_cnt;
    logic                  r_m_valid;
    logic                  r_m_we;
    logic [ADDR_W-1:0]     r_m_addr;
    logic [DATA_W-1:0]     r_m_wdata;
    logic [C_STRB_W-1:0]   r_m_wstrb;
    logic [DATA_W-1:0]     r_i_rdata;
    logic [DATA_W-1:0]     r_d_rdata;
    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_bus_done;
    logic                  w_timeout;
    logic [DATA_W-1:0]     w_rdata_cap;

    assign m_valid = r_m_valid;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_bus_done  = 1'b0;
        busy        = (r_state != IDLE);
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_valid && (!i_valid || (r_starve_cnt < C_STARVE_MAX))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = D_BUS;
                end else if (i_valid) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = I_BUS;
                end
            end
            I_BUS, D_BUS: begin
                if (m_ready || w_timeout) begin
                    w_bus_done  = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                i_ready     = (r_owner == OWN_I);
                d_ready     = (r_owner == OWN_D);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A real m_ready wins over a timeout landing in the same cycle.
    assign w_rdata_cap = m_ready ? m_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_I;
            r_starve_cnt <= '0;
            r_m_valid    <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_wstrb    <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner   <= OWN_D;
                r_m_valid <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
                r_m_wstrb <= d_wstrb;
                if (i_valid && (r_starve_cnt < C_STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (w_grant_i) begin
                r_owner      <= OWN_I;
                r_m_valid    <= 1'b1;
                r_m_we       <= 1'b0;
                r_m_addr     <= i_addr;
                r_m_wdata    <= '0;
                r_m_wstrb    <= '0;
                r_starve_cnt <= '0;
            end
            if (w_bus_done) begin
                r_m_valid <= 1'b0;
                if (r_owner == OWN_I) begin
                    r_i_rdata <= w_rdata_cap;
                end else begin
                    r_d_rdata <= r_m_we ? '0 : w_rdata_cap;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_in_bus;
    logic r_err;

    assign w_in_bus = (r_state == I_BUS) || (r_state == D_BUS);
    assign err      = r_err;

    mem_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!w_in_bus || m_ready),
        .en     (w_in_bus && !m_ready),
        .expire (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout && !m_ready) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed bench with a transaction-level reference model
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    localparam int C_STARVE = 4;
    localparam int C_TMO    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, d_valid, d_we, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;
    logic        i_ready, d_ready, m_valid, m_we, busy, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    int n_vec = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .ADDR_W (32), .DATA_W (32), .STARVE_MAX (C_STARVE), .TIMEOUT_CYC (C_TMO)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .i_valid (i_valid), .i_addr (i_addr), .i_ready (i_ready), .i_rdata (i_rdata),
        .d_valid (d_valid), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_wstrb (d_wstrb), .d_ready (d_ready), .d_rdata (d_rdata),
        .m_valid (m_valid), .m_we (m_we), .m_addr (m_addr), .m_wdata (m_wdata),
        .m_wstrb (m_wstrb), .m_ready (m_ready), .m_rdata (m_rdata),
        .busy (busy), .err (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is either on the bus, in its response
    // cycle, or absent; grants follow the priority/starvation rule directly.
    bit          mdl_bus = 0, mdl_resp = 0, mdl_own_d = 0, mdl_err = 0, mdl_we = 0;
    logic [31:0] mdl_addr = 0, mdl_wdata = 0, mdl_i_rdata = 0, mdl_d_rdata = 0;
    logic [3:0]  mdl_wstrb = 0;
    int          mdl_starve = 0, mdl_wait = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_bus = 0; mdl_resp = 0; mdl_own_d = 0; mdl_err = 0; mdl_we = 0;
            mdl_addr = 0; mdl_wdata = 0; mdl_wstrb = 0;
            mdl_i_rdata = 0; mdl_d_rdata = 0; mdl_starve = 0; mdl_wait = 0;
        end else if (mdl_resp) begin
            mdl_resp = 0;
        end else if (mdl_bus) begin
            if (m_ready) begin
                if (mdl_own_d) mdl_d_rdata = mdl_we ? 32'h0 : m_rdata;
                else           mdl_i_rdata = m_rdata;
                mdl_bus = 0; mdl_resp = 1;
            end else begin
                mdl_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
                if (mdl_wait >= C_TMO) begin
                    if (mdl_own_d) mdl_d_rdata = 0;
                    else           mdl_i_rdata = 0;
                    mdl_err = 1; mdl_bus = 0; mdl_resp = 1;
                end
`endif
            end
        end else if (d_valid && (!i_valid || mdl_starve < C_STARVE)) begin
            mdl_bus = 1; mdl_own_d = 1; mdl_wait = 0;
            mdl_we = d_we; mdl_addr = d_addr; mdl_wdata = d_wdata; mdl_wstrb = d_wstrb;
            if (i_valid && mdl_starve < C_STARVE) mdl_starve++;
        end else if (i_valid) begin
            mdl_bus = 1; mdl_own_d = 0; mdl_wait = 0;
            mdl_we = 0; mdl_addr = i_addr; mdl_wstrb = 0;
            mdl_starve = 0;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", m_valid, mdl_bus);
        chk("busy", busy, mdl_bus | mdl_resp);
        chk("i_ready", i_ready, mdl_resp & ~mdl_own_d);
        chk("d_ready", d_ready, mdl_resp & mdl_own_d);
        chk("i_rdata", i_rdata, mdl_i_rdata);
        chk("d_rdata", d_rdata, mdl_d_rdata);
        chk("err", err, mdl_err);
        chk("rdy_with_mvalid", i_ready | d_ready, (i_ready | d_ready) & ~m_valid);
        if (mdl_bus) begin
            chk("m_addr", m_addr, mdl_addr);
            chk("m_we", m_we, mdl_we);
            chk("m_wstrb", m_wstrb, mdl_wstrb);
            if (mdl_own_d) chk("m_wdata", m_wdata, mdl_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_valid = 0; i_addr = 0; d_valid = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; m_ready = 0; m_rdata = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        string pat;
        string exp_pat;
        int    n;

        do_reset();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_err", err, 0);

        // Single fetch, zero-wait bus
        i_valid = 1; i_addr = 32'h100; m_ready = 1; m_rdata = 32'h0000_0013;
        tick();
        chk("fetch_m_valid_c1", m_valid, 1);
        chk("fetch_m_addr_c1", m_addr, 32'h100);
        chk("fetch_m_we_c1", m_we, 0);
        tick();
        chk("fetch_i_ready_c2", i_ready, 1);
        chk("fetch_i_rdata_c2", i_rdata, 32'h13);
        i_valid = 0;
        tick();
        chk("fetch_i_ready_c3", i_ready, 0);

        // Store then load
        d_valid = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        m_rdata = 32'h1234_5678;
        tick();
        chk("store_m_we", m_we, 1);
        chk("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
        tick();
        chk("store_d_ready", d_ready, 1);
        chk("store_d_rdata", d_rdata, 0);
        d_valid = 0;
        tick();
        d_valid = 1; d_we = 0; d_wstrb = 0; m_rdata = 32'hDEAD_BEEF;
        tick();
        chk("load_m_we", m_we, 0);
        tick();
        chk("load_d_ready", d_ready, 1);
        chk("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("load_i_rdata_hold", i_rdata, 32'h13);
        d_valid = 0;
        tick();

        // Starvation: both requesters held high
        do_reset();
        i_valid = 1; i_addr = 32'h400; d_valid = 1; d_addr = 32'h800; m_ready = 1;
        m_rdata = 32'h55;
        pat = "";
        exp_pat = "DDDDIDDDDI";
        n = 0;
        while (pat.len() < 10 && n < 60) begin
            tick();
            n++;
            if (m_valid) pat = {pat, (m_addr == 32'h800) ? "D" : "I"};
        end
        chk("starve_grant_count", pat.len(), 10);
        for (int k = 0; k < 10 && k < pat.len(); k++)
            chk($sformatf("starve_grant%0d", k), pat[k], exp_pat[k]);
        i_valid = 0; d_valid = 0;
        repeat (3) tick();

        // Wait states with fetch redirect
        do_reset();
        i_valid = 1; i_addr = 32'h300; m_ready = 0; m_rdata = 32'hAAAA_5555;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) i_valid = 0;
            chk($sformatf("wait_m_valid_c%0d", c), m_valid, 1);
            chk($sformatf("wait_m_addr_c%0d", c), m_addr, 32'h300);
        end
        tick();
        m_ready = 1;
        chk("wait_m_valid_c6", m_valid, 1);
        chk("wait_i_ready_c6", i_ready, 0);
        tick();
        chk("wait_i_ready_c7", i_ready, 1);
        chk("wait_i_rdata_c7", i_rdata, 32'hAAAA_5555);
        tick();
        chk("wait_i_ready_c8", i_ready, 0);

        // Reset mid D transaction
        do_reset();
        d_valid = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'h77; d_wstrb = 4'h3; m_ready = 0;
        tick();
        tick();
        chk("rmid_m_valid_before", m_valid, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rmid_m_valid_async", m_valid, 0);
        chk("rmid_busy_async", busy, 0);
        i_valid = 1; i_addr = 32'h104; d_we = 0; d_addr = 32'h704; m_ready = 1; m_rdata = 32'h9;
        tick();
        rst_n = 1;
        chk("rmid_busy_after", busy, 0);
        tick();
        chk("rmid_first_grant_addr", m_addr, 32'h704);
        tick();
        chk("rmid_d_ready", d_ready, 1);
        d_valid = 0;
        repeat (4) tick();
        chk("rmid_i_served", i_rdata, 32'h9);
        i_valid = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Bus never answers
        do_reset();
        d_valid = 1; d_we = 0; d_addr = 32'h900; m_ready = 0; m_rdata = 32'hFFFF_FFFF;
        tick();
        n = 0;
        while (m_valid && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_m_valid_cycles", n, C_TMO);
        chk("tmo_d_ready", d_ready, 1);
        chk("tmo_d_rdata", d_rdata, 0);
        chk("tmo_err", err, 1);
        d_valid = 0;
        repeat (3) tick();
        chk("tmo_err_sticky", err, 1);
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
